// File: rtl/seg7_readback_decoder.sv
// Receive side of a multiplexed active-low 7-segment bus: synchronizes the pins,
// waits for each strobed digit to settle, decodes it to BCD and publishes full frames.
// Optional build macro ERR_COUNT_EN adds a saturating err_count output.
module seg7_readback_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   anode_n,
  output logic [4*NUM_DIGITS-1:0] bcd_frame,
  output logic                    frame_valid,
  output logic                    pattern_err,
  output logic                    anode_err
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // {error, nibble}: blank maps to 4'hA, anything unrecognised to 4'hF with error set.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'h40:   return {1'b0, 4'h0};
      7'h79:   return {1'b0, 4'h1};
      7'h24:   return {1'b0, 4'h2};
      7'h30:   return {1'b0, 4'h3};
      7'h19:   return {1'b0, 4'h4};
      7'h12:   return {1'b0, 4'h5};
      7'h02:   return {1'b0, 4'h6};
      7'h78:   return {1'b0, 4'h7};
      7'h00:   return {1'b0, 4'h8};
      7'h10:   return {1'b0, 4'h9};
      7'h7F:   return {1'b0, 4'hA};
      default: return {1'b1, 4'hF};
    endcase
  endfunction

  // Two-flop synchronizers. They reset to the idle (all-high) pin level so that
  // leaving reset never looks like every anode being strobed at once.
  logic [6:0]            seg_meta_q,   seg_sync_q;
  logic [NUM_DIGITS-1:0] anode_meta_q, anode_sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_meta_q   <= '1;
      seg_sync_q   <= '1;
      anode_meta_q <= '1;
      anode_sync_q <= '1;
    end else begin
      seg_meta_q   <= seg_n;
      seg_sync_q   <= seg_meta_q;
      anode_meta_q <= anode_n;
      anode_sync_q <= anode_meta_q;
    end
  end

  logic             any_low, multi_low, single_low;
  logic [IDX_W-1:0] low_idx;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    any_low   = 1'b0;
    multi_low = 1'b0;
    low_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!anode_sync_q[i]) begin
        if (any_low) multi_low = 1'b1;
        any_low = 1'b1;
        low_idx = IDX_W'(i);
      end
    end
    single_low = any_low & ~multi_low;
  end

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [6:0]       pat_q,   pat_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             capture;
  logic             restart;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (single_low) restart = 1'b1;
      end
      ST_SETTLE: begin
        if (!single_low) begin
          state_d = ST_IDLE;
        end else if (low_idx != idx_q || seg_sync_q != pat_q) begin
          restart = 1'b1;
        end else if (cnt_q == CNT_CAP) begin
          cnt_d   = cnt_q + CNT_ONE;
          capture = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        // One capture per strobe: later pattern changes on the same anode are ignored.
        if (!single_low) begin
          state_d = ST_IDLE;
        end else if (low_idx != idx_q) begin
          restart = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart) begin
      state_d = ST_SETTLE;
      idx_d   = low_idx;
      pat_d   = seg_sync_q;
      cnt_d   = CNT_ONE;
    end
  end

  logic [4:0]              decoded;
  logic                    frame_done;
  logic [4*NUM_DIGITS-1:0] shadow_q,      shadow_d;
  logic [NUM_DIGITS-1:0]   mask_q,        mask_d;
  logic [4*NUM_DIGITS-1:0] bcd_frame_q,   bcd_frame_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    pattern_err_q, pattern_err_d;
  logic                    anode_err_q,   anode_err_d;

  assign decoded    = decode_seg(pat_q);
  assign frame_done = &mask_q;

  always_comb begin
    shadow_d      = shadow_q;
    mask_d        = frame_done ? '0 : mask_q;
    bcd_frame_d   = frame_done ? shadow_q : bcd_frame_q;
    frame_valid_d = frame_done;
    pattern_err_d = capture & decoded[4];
    anode_err_d   = multi_low;
    if (capture) begin
      shadow_d[4*int'(idx_q) +: 4] = decoded[3:0];
      mask_d[idx_q]                = 1'b1;
    end
  end

  // NOTE: the shadow frame is a handful of flops, not a RAM, so it is reset with the rest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      pat_q         <= '1;
      cnt_q         <= '0;
      shadow_q      <= '0;
      mask_q        <= '0;
      bcd_frame_q   <= '0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pat_q         <= pat_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      bcd_frame_q   <= bcd_frame_d;
      frame_valid_q <= frame_valid_d;
      pattern_err_q <= pattern_err_d;
      anode_err_q   <= anode_err_d;
    end
  end

  assign bcd_frame   = bcd_frame_q;
  assign frame_valid = frame_valid_q;
  assign pattern_err = pattern_err_q;
  assign anode_err   = anode_err_q;

`ifdef ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (pattern_err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_count_q <= '0;
    else          err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder: scans hand-built displays and checks
// frames, error pulses and reset behaviour against hand-computed values.
module tb_seg7_readback_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [5:0]  anode_n = 6'h3F;
  logic [23:0] bcd_frame;
  logic        frame_valid;
  logic        pattern_err;
  logic        anode_err;
`ifdef ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  seg7_readback_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_n       (seg_n),
    .anode_n     (anode_n),
    .bcd_frame   (bcd_frame),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err),
    .anode_err   (anode_err)
`ifdef ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitors, sampled 2 ns after each rising edge.
  int          fv_cnt = 0;
  int          perr_cnt = 0;
  int          aerr_cnt = 0;
  logic [23:0] last_frame = '0;

  always @(posedge clk) begin
    #2;
    if (frame_valid) begin
      fv_cnt     <= fv_cnt + 1;
      last_frame <= bcd_frame;
    end
    if (pattern_err) perr_cnt <= perr_cnt + 1;
    if (anode_err)   aerr_cnt <= aerr_cnt + 1;
  end

  // Index 0..9 are the digits, index 10 (4'hA) is the blank pattern.
  logic [6:0] seg_tab [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All drives happen right after a falling edge and hold for n clocks.
  task automatic show(input int d, input logic [6:0] pat, input int n);
    logic [5:0] a;
    a       = '1;
    a[d]    = 1'b0;
    anode_n = a;
    seg_n   = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    anode_n = '1;
    seg_n   = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int fv0, pe0, ae0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bcd_frame",   32'(bcd_frame),   32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_pattern_err", 32'(pattern_err), 32'h0);
    check("rst_anode_err",   32'(anode_err),   32'h0);
    reset_n = 1'b1;
    idle(4);

    // 1) Scan 12:34:56, 8 clocks per digit, d5 first
    fv0 = fv_cnt; pe0 = perr_cnt;
    show(5, seg_tab[1], 8);
    show(4, seg_tab[2], 8);
    show(3, seg_tab[3], 8);
    show(2, seg_tab[4], 8);
    show(1, seg_tab[5], 8);
    check("t1_no_early_frame", fv_cnt - fv0, 0);
    show(0, seg_tab[6], 8);
    idle(4);
    check("t1_frame_count", fv_cnt - fv0, 1);
    check("t1_frame_value", 32'(last_frame), 32'h123456);
    check("t1_frame_holds", 32'(bcd_frame),  32'h123456);
    check("t1_no_perr",     perr_cnt - pe0, 0);

    // 2) d2 shows 2 for 3 clocks then 3 for 5 clocks: only 3 is captured
    fv0 = fv_cnt; pe0 = perr_cnt;
    show(5, seg_tab[9], 8);
    show(4, seg_tab[8], 8);
    show(3, seg_tab[7], 8);
    show(2, 7'h24, 3);
    show(2, 7'h30, 5);
    show(1, seg_tab[1], 8);
    show(0, seg_tab[0], 8);
    idle(4);
    check("t2_frame_count", fv_cnt - fv0, 1);
    check("t2_frame_value", 32'(last_frame), 32'h987310);
    check("t2_no_perr",     perr_cnt - pe0, 0);

    // 3) Undecodable pattern 7'h55 on d0
    fv0 = fv_cnt; pe0 = perr_cnt;
    show(5, seg_tab[2], 8);
    show(4, seg_tab[3], 8);
    show(3, seg_tab[5], 8);
    show(2, seg_tab[9], 8);
    show(1, seg_tab[4], 8);
    show(0, 7'h55, 8);
    idle(4);
    check("t3_frame_count", fv_cnt - fv0, 1);
    check("t3_frame_value", 32'(last_frame), 32'h23594F);
    check("t3_perr_pulse",  perr_cnt - pe0, 1);
`ifdef ERR_COUNT_EN
    check("t3_err_count",   32'(err_count), 32'h1);
`endif

    // 4) Two anodes low for 5 clocks in the middle of a sweep
    fv0 = fv_cnt; pe0 = perr_cnt;
    show(5, seg_tab[0], 8);
    show(4, seg_tab[7], 8);
    show(3, seg_tab[1], 8);
    ae0 = aerr_cnt;
    anode_n = 6'b111100;
    seg_n   = 7'h24;
    repeat (5) @(negedge clk);
    idle(4);
    check("t4_anode_err_cycles", aerr_cnt - ae0, 5);
    check("t4_no_frame_yet",     fv_cnt - fv0, 0);
    show(2, seg_tab[8], 8);
    show(1, seg_tab[2], 8);
    show(0, seg_tab[6], 8);
    idle(4);
    check("t4_frame_count", fv_cnt - fv0, 1);
    check("t4_frame_value", 32'(last_frame), 32'h071826);
    check("t4_no_perr",     perr_cnt - pe0, 0);

    // 5) Blank d4, out-of-order sweep with d0 recaptured before completion
    fv0 = fv_cnt; pe0 = perr_cnt;
    show(0, seg_tab[7], 8);
    show(5, seg_tab[5], 8);
    show(0, seg_tab[4], 8);
    show(4, seg_tab[10], 8);
    show(3, seg_tab[3], 8);
    show(2, seg_tab[0], 8);
    check("t5_no_early_frame", fv_cnt - fv0, 0);
    show(1, seg_tab[9], 8);
    idle(4);
    check("t5_frame_count", fv_cnt - fv0, 1);
    check("t5_frame_value", 32'(last_frame), 32'h5A3094);
    check("t5_blank_no_perr", perr_cnt - pe0, 0);

    // 6) Reset after 3 captured digits discards the partial frame
    show(5, seg_tab[8], 8);
    show(4, seg_tab[8], 8);
    show(3, seg_tab[8], 8);
    idle(2);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_rst_bcd_frame",   32'(bcd_frame),   32'h0);
    check("t6_rst_frame_valid", 32'(frame_valid), 32'h0);
    check("t6_rst_pattern_err", 32'(pattern_err), 32'h0);
    check("t6_rst_anode_err",   32'(anode_err),   32'h0);
`ifdef ERR_COUNT_EN
    check("t6_rst_err_count",   32'(err_count),   32'h0);
`endif
    reset_n = 1'b1;
    idle(4);
    fv0 = fv_cnt;
    show(2, seg_tab[4], 8);
    show(1, seg_tab[5], 8);
    show(0, seg_tab[6], 8);
    idle(4);
    check("t6_no_partial_frame", fv_cnt - fv0, 0);
    check("t6_frame_still_zero", 32'(bcd_frame), 32'h0);
    show(5, seg_tab[2], 8);
    show(4, seg_tab[3], 8);
    show(3, seg_tab[3], 8);
    idle(4);
    check("t6_frame_count", fv_cnt - fv0, 1);
    check("t6_frame_value", 32'(last_frame), 32'h233456);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
